move_arbiter: RTL and testbench

MOVE_ARBITER -- requirements
Module: move_arbiter

---
 rtl/tetris_pkg.sv | 23 ++
 rtl/key_decoder.sv | 44 ++++
 rtl/move_arbiter.sv | 89 ++++++++
 tb/tb_move_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: command encodings, keyboard scancodes and speed-level thresholds
// shared by the move arbiter and its key decoder.
package tetris_pkg;

    localparam logic [2:0] OP_DROP   = 3'd0;
    localparam logic [2:0] OP_LEFT   = 3'd1;
    localparam logic [2:0] OP_RIGHT  = 3'd2;
    localparam logic [2:0] OP_ROTATE = 3'd3;
    localparam logic [2:0] OP_SOFT   = 3'd4;

    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_ROTATE = 8'h75;
    localparam logic [7:0] SC_SOFT   = 8'h72;

    localparam logic [31:0] LVL1_SCORE = 32'd3;
    localparam logic [31:0] LVL2_SCORE = 32'd5;

    function automatic logic [1:0] level_of(input logic [31:0] score);
        return score < LVL1_SCORE ? 2'd0 : score < LVL2_SCORE ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/key_decoder.sv
// key_decoder: synchronizes the keyboard strobe, detects its rising edge,
// decodes the scancode and enforces the post-key lockout window.
module key_decoder
    import tetris_pkg::*;
#(
    parameter int unsigned KEY_GAP = 4000000
) (
    input  logic       iVGA_CLK,
    input  logic       rst,
    input  logic       press,
    input  logic [7:0] ps2_out,
    output logic       key_hit,
    output logic [2:0] key_op
);

    localparam int LW = $clog2(KEY_GAP + 1);

    logic          s1, s2, s3;
    logic          known;
    logic [LW-1:0] lock;

    assign known   = ps2_out == SC_LEFT || ps2_out == SC_RIGHT ||
                     ps2_out == SC_ROTATE || ps2_out == SC_SOFT;
    assign key_op  = ps2_out == SC_LEFT   ? OP_LEFT   :
                     ps2_out == SC_RIGHT  ? OP_RIGHT  :
                     ps2_out == SC_ROTATE ? OP_ROTATE : OP_SOFT;
    // Unknown codes never reach key_hit, so they cannot start a lockout.
    assign key_hit = s2 && !s3 && known && lock == '0;

    always_ff @(posedge iVGA_CLK or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            lock <= '0;
        end else begin
            s1   <= press;
            s2   <= s1;
            s3   <= s2;
            lock <= key_hit ? LW'(KEY_GAP - 1) : lock != '0 ? lock - LW'(1) : lock;
        end
    end

endmodule

// File: rtl/move_arbiter.sv
// move_arbiter: merges gravity drops and keyboard moves into a single
// valid/ready command stream with one command in flight at a time.
module move_arbiter
    import tetris_pkg::*;
#(
    parameter int unsigned DIV_L0  = 11000000,
    parameter int unsigned DIV_L1  = 8000000,
    parameter int unsigned DIV_L2  = 6000000,
    parameter int unsigned KEY_GAP = 4000000
) (
    input  logic        iVGA_CLK,
    input  logic        rst,
    input  logic [31:0] current_score,
    input  logic        press,
    input  logic [7:0]  ps2_out,
    input  logic        move_reset,
    output logic        cmd_valid,
    output logic [2:0]  cmd_op,
    input  logic        cmd_ready,
    output logic [1:0]  level
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]  state;
    logic [31:0] grav_cnt, div;
    logic        expire, served, key_hit, key_new;
    logic        drop_pend, key_pend, is_key;
    logic [2:0]  dec_op, key_op;

    key_decoder #(.KEY_GAP(KEY_GAP)) u_key (
        .iVGA_CLK(iVGA_CLK),
        .rst     (rst),
        .press   (press),
        .ps2_out (ps2_out),
        .key_hit (key_hit),
        .key_op  (dec_op)
    );

    assign div     = level == 2'd0 ? DIV_L0 : level == 2'd1 ? DIV_L1 : DIV_L2;
    assign expire  = grav_cnt >= div - 32'd1;
    assign served  = state == ISSUE && cmd_ready && !move_reset;
    // A repeat of the key command currently on offer is dropped, not queued.
    assign key_new = key_hit && !(state == ISSUE && is_key && cmd_op == dec_op);

    always_ff @(posedge iVGA_CLK or posedge rst) begin
        if (rst) begin
            level     <= 2'd0;
            grav_cnt  <= 32'd0;
            drop_pend <= 1'b0;
            key_pend  <= 1'b0;
            key_op    <= OP_DROP;
        end else begin
            level  <= level_of(current_score);
            key_op <= key_new ? dec_op : key_op;
            if (move_reset) begin
                grav_cnt  <= 32'd0;
                drop_pend <= 1'b0;
                key_pend  <= 1'b0;
            end else begin
                grav_cnt  <= expire ? 32'd0 : grav_cnt + 32'd1;
                drop_pend <= expire || (drop_pend && !(served && !is_key));
                key_pend  <= key_new || (key_pend && !(served && is_key));
            end
        end
    end

    always_ff @(posedge iVGA_CLK or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            cmd_op    <= OP_DROP;
            is_key    <= 1'b0;
        end else if (move_reset) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
        end else if (state == IDLE && (key_pend || drop_pend)) begin
            state     <= ISSUE;
            cmd_valid <= 1'b1;
            cmd_op    <= key_pend ? key_op : OP_DROP;
            is_key    <= key_pend;
        end else if (served) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_move_arbiter.sv
// tb_move_arbiter: directed stimulus with a scoreboard of expected command ops
// drained by a handshake monitor, plus timing checks on cmd_valid and level.
module tb_move_arbiter;

    localparam logic [2:0] DROP  = 3'd0;
    localparam logic [2:0] LEFT  = 3'd1;
    localparam logic [2:0] RIGHT = 3'd2;
    localparam logic [2:0] ROT   = 3'd3;

    logic        iVGA_CLK = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] current_score = 32'd0;
    logic        press = 1'b0;
    logic [7:0]  ps2_out = 8'h00;
    logic        move_reset = 1'b0;
    logic        cmd_ready = 1'b1;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [1:0]  level;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [2:0]  exp_q[$];
    int          hs_t[$];

    move_arbiter #(.DIV_L0(10), .DIV_L1(8), .DIV_L2(6), .KEY_GAP(20)) dut (
        .iVGA_CLK     (iVGA_CLK),
        .rst          (rst),
        .current_score(current_score),
        .press        (press),
        .ps2_out      (ps2_out),
        .move_reset   (move_reset),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_ready    (cmd_ready),
        .level        (level)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    always @(posedge iVGA_CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge iVGA_CLK);
    endtask

    task automatic hold_reset(input int n);
        move_reset = 1'b1;
        step(n);
        move_reset = 1'b0;
    endtask

    // Inputs settle at the falling edge; 1 time unit later they describe the coming edge.
    always @(negedge iVGA_CLK) begin
        #1;
        if (!rst && cmd_valid && cmd_ready && !move_reset) begin
            hs_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_cmd: got op %0d, expected no command", cmd_op);
            end else begin
                check("sb_op", cmd_op, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic early, stable;
        step(2);
        check("rst_valid", cmd_valid, 0);
        check("rst_op", cmd_op, 0);
        check("rst_level", level, 0);

        // Gravity only: DROP every 10 cycles
        rst = 1'b0;
        repeat (3) exp_q.push_back(DROP);
        early = 1'b0;
        repeat (10) begin step(1); early |= cmd_valid; end
        check("first_drop_not_early", early, 0);
        step(1);
        check("first_drop_valid", cmd_valid, 1);
        check("first_drop_op", cmd_op, DROP);
        for (int i = 0; i < 60 && hs_t.size() < 3; i++) step(1);
        check("drop_count", hs_t.size(), 3);
        if (hs_t.size() >= 3) begin
            check("drop_interval_1", hs_t[1] - hs_t[0], 10);
            check("drop_interval_2", hs_t[2] - hs_t[1], 10);
        end

        // LEFT key, then a second LEFT inside the lockout window
        hold_reset(3);
        exp_q.push_back(LEFT);
        exp_q.push_back(DROP);
        press = 1'b1; ps2_out = 8'h6B;
        step(2); press = 1'b0;
        step(1); check("left_not_before_4", cmd_valid, 0);
        step(1); check("left_valid", cmd_valid, 1); check("left_op", cmd_op, LEFT);
        step(1); press = 1'b1;
        step(2); press = 1'b0;
        early = 1'b0;
        repeat (3) begin step(1); early |= cmd_valid; end
        check("second_left_locked", early, 0);
        step(1); check("drop_after_left", cmd_valid, 1); check("drop_after_left_op", cmd_op, DROP);
        step(1);
        hold_reset(25);

        // Gravity expiry and ROTATE in the same cycle, ready withheld 5 cycles
        cmd_ready = 1'b0;
        exp_q.push_back(ROT);
        exp_q.push_back(DROP);
        step(7); press = 1'b1; ps2_out = 8'h75;
        step(2); press = 1'b0;
        step(1); check("rot_not_yet", cmd_valid, 0);
        stable = 1'b1;
        repeat (5) begin step(1); if (!(cmd_valid === 1'b1 && cmd_op === ROT)) stable = 1'b0; end
        check("rot_held_5", stable, 1);
        cmd_ready = 1'b1;
        step(1); check("idle_gap", cmd_valid, 0);
        step(1); check("drop_after_rot", cmd_valid, 1); check("drop_after_rot_op", cmd_op, DROP);
        step(1);
        hold_reset(3);

        // Score 0->5 with counter at 7: level 2 and an immediate expiry
        exp_q.push_back(DROP);
        step(7); check("level_before", level, 0); current_score = 32'd5;
        step(1); check("level_2", level, 2); check("no_drop_yet", cmd_valid, 0);
        step(1); check("drop_pending_only", cmd_valid, 0);
        step(1); check("fast_drop", cmd_valid, 1);
        step(1);
        move_reset = 1'b1;
        current_score = 32'd4; step(2); check("level_at_4", level, 1);
        current_score = 32'd3; step(2); check("level_at_3", level, 1);
        current_score = 32'd2; step(2); check("level_at_2", level, 0);
        current_score = 32'd0; step(2);
        move_reset = 1'b0;

        // move_reset while a DROP is on offer and not accepted
        cmd_ready = 1'b0;
        step(11); check("drop_on_offer", cmd_valid, 1);
        move_reset = 1'b1;
        step(1); move_reset = 1'b0; check("mr_clears_valid", cmd_valid, 0);
        cmd_ready = 1'b1;
        step(1); check("mr_no_pend", cmd_valid, 0);
        exp_q.push_back(DROP);
        early = 1'b0;
        repeat (9) begin step(1); early |= cmd_valid; end
        check("mr_full_interval", early, 0);
        step(1); check("drop_after_mr", cmd_valid, 1);
        step(1);
        hold_reset(3);

        // Asynchronous reset in the middle of a RIGHT command
        cmd_ready = 1'b0;
        current_score = 32'd5;
        press = 1'b1; ps2_out = 8'h74;
        step(2); press = 1'b0;
        step(2); check("right_valid", cmd_valid, 1); check("right_op", cmd_op, RIGHT); check("level_pre_rst", level, 2);
        step(1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", cmd_valid, 0);
        check("async_rst_op", cmd_op, 0);
        check("async_rst_level", level, 0);
        press = 1'b1; ps2_out = 8'h6B;
        step(2); press = 1'b0;
        step(1);
        current_score = 32'd0;
        cmd_ready = 1'b1;
        rst = 1'b0;
        exp_q.push_back(DROP);
        early = 1'b0;
        repeat (10) begin step(1); early |= cmd_valid; end
        check("no_key_from_reset", early, 0);
        step(1); check("drop_after_rst", cmd_valid, 1); check("drop_after_rst_op", cmd_op, DROP);
        step(3);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
